// File: rtl/dso100fb_fetch_ctrl.sv
// Framebuffer fetch controller: splits each frame into DataMover MM2S commands and checks every status beat.
// Define DSO100FB_FETCH_STATS_EN to build the frame/overrun statistics counters.
module dso100fb_fetch_ctrl #(
  parameter int ADDR_WIDTH      = 32,
  parameter int BTT_WIDTH       = 23,
  parameter int LEN_WIDTH       = 26,
  parameter int CHUNK_BYTES     = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             FETCH_EN,
  input  logic                             FETCH_START,
  input  logic [ADDR_WIDTH-1:0]            FETCH_FB_BASE,
  input  logic [LEN_WIDTH-1:0]             FETCH_FB_LENGTH,
  output logic [ADDR_WIDTH+BTT_WIDTH+16:0] MCMD_TDATA,
  output logic                             MCMD_TVALID,
  input  logic                             MCMD_TREADY,
  input  logic [7:0]                       MSTS_TDATA,
  input  logic                             MSTS_TVALID,
  output logic                             MSTS_TREADY,
  output logic                             FETCH_BUSY,
  output logic                             FETCH_DONE,
  output logic                             FETCH_ERR,
  input  logic                             FETCH_ERR_CLR,
  output logic [15:0]                      STAT_FRAMES,
  output logic [15:0]                      STAT_OVERRUN
);

  localparam int                   CMD_WIDTH = ADDR_WIDTH + BTT_WIDTH + 17;
  localparam logic [LEN_WIDTH-1:0] CHUNK_LEN = LEN_WIDTH'(CHUNK_BYTES);
  localparam logic [3:0]           OUT_MAX   = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   rem_q;
  logic [3:0]             tag_q;
  logic [3:0]             exp_tag_q;
  logic [3:0]             outstanding_q;
  logic                   cmd_valid_q;
  logic [CMD_WIDTH-1:0]   cmd_data_q;
  logic                   done_q;
  logic                   err_q;

  logic                   start_accept;
  logic                   raise_cmd;
  logic                   done_d;
  logic                   cmd_hs;
  logic                   last_chunk;
  logic [LEN_WIDTH-1:0]   chunk_len;
  logic                   sts_consume;
  logic                   sts_fault;

  // Command stream: a beat transfers when MCMD_TVALID && MCMD_TREADY on a rising edge;
  // once raised, TVALID and TDATA hold unchanged until that transfer, and TVALID
  // drops for at least one cycle after each transfer. Status is always accepted.
  assign cmd_hs = cmd_valid_q && MCMD_TREADY;

  always_comb begin
    last_chunk = (rem_q <= CHUNK_LEN);
    chunk_len  = last_chunk ? rem_q : CHUNK_LEN;
  end

  // A status beat with nothing outstanding is spurious and must not decrement the counter.
  always_comb begin
    sts_consume = MSTS_TVALID && (outstanding_q != 4'd0);
    sts_fault   = MSTS_TVALID && (!MSTS_TDATA[7] || (MSTS_TDATA[6:4] != 3'b000) ||
                                  (MSTS_TDATA[3:0] != exp_tag_q) || (outstanding_q == 4'd0));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    start_accept = 1'b0;
    raise_cmd    = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (FETCH_START && FETCH_EN) begin
          start_accept = 1'b1;
          if (FETCH_FB_LENGTH == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        raise_cmd = !cmd_valid_q && FETCH_EN && (rem_q != '0) && (outstanding_q < OUT_MAX);
        if (cmd_hs && last_chunk) begin
          state_d = ST_DRAIN;
        end else if (!cmd_valid_q && !FETCH_EN) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outstanding_q == 4'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q        <= '0;
      rem_q         <= '0;
      tag_q         <= 4'd0;
      exp_tag_q     <= 4'd0;
      outstanding_q <= 4'd0;
      cmd_valid_q   <= 1'b0;
      cmd_data_q    <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      if (start_accept) begin
        addr_q <= FETCH_FB_BASE;
        rem_q  <= FETCH_FB_LENGTH;
      end else if (cmd_hs) begin
        addr_q <= addr_q + ADDR_WIDTH'(chunk_len);
        rem_q  <= rem_q - chunk_len;
      end

      if (cmd_hs) begin
        tag_q <= tag_q + 4'd1;
      end

      // Command word is built from the already-advanced addr/rem/tag of the previous transfer.
      if (cmd_hs) begin
        cmd_valid_q <= 1'b0;
      end else if (raise_cmd) begin
        cmd_valid_q <= 1'b1;
        cmd_data_q  <= {4'b0000, tag_q, addr_q, 1'b0, last_chunk, 6'b000000, 1'b1,
                        BTT_WIDTH'(chunk_len)};
      end

      case ({cmd_hs, sts_consume})
        2'b10:   outstanding_q <= outstanding_q + 4'd1;
        2'b01:   outstanding_q <= outstanding_q - 4'd1;
        default: outstanding_q <= outstanding_q;
      endcase

      if (sts_consume) begin
        exp_tag_q <= exp_tag_q + 4'd1;
      end

      done_q <= done_d;

      if (sts_fault) begin
        err_q <= 1'b1;
      end else if (FETCH_ERR_CLR) begin
        err_q <= 1'b0;
      end
    end
  end

  assign MCMD_TDATA  = cmd_data_q;
  assign MCMD_TVALID = cmd_valid_q;
  assign MSTS_TREADY = 1'b1;
  assign FETCH_BUSY  = (state_q != ST_IDLE);
  assign FETCH_DONE  = done_q;
  assign FETCH_ERR   = err_q;

`ifdef DSO100FB_FETCH_STATS_EN
  logic [15:0] frames_q;
  logic [15:0] overrun_q;

  // Frame count moves on the same edge that raises FETCH_DONE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frames_q  <= 16'd0;
      overrun_q <= 16'd0;
    end else begin
      if (done_d) begin
        frames_q <= frames_q + 16'd1;
      end
      if (FETCH_START && (state_q != ST_IDLE) && (overrun_q != 16'hFFFF)) begin
        overrun_q <= overrun_q + 16'd1;
      end
    end
  end

  assign STAT_FRAMES  = frames_q;
  assign STAT_OVERRUN = overrun_q;
`else
  assign STAT_FRAMES  = 16'd0;
  assign STAT_OVERRUN = 16'd0;
`endif

endmodule

// File: tb/tb_dso100fb_fetch_ctrl.sv
// Self-checking bench for dso100fb_fetch_ctrl: directed scenarios plus randomized frames
// compared against a chunking model and a status-tag queue.
module tb_dso100fb_fetch_ctrl;

  localparam int AW    = 32;
  localparam int BW    = 23;
  localparam int LW    = 26;
  localparam int CHUNK = 4096;
  localparam int CW    = AW + BW + 17;

  logic          CLK;
  logic          RST_N;
  logic          FETCH_EN;
  logic          FETCH_START;
  logic [AW-1:0] FETCH_FB_BASE;
  logic [LW-1:0] FETCH_FB_LENGTH;
  logic [CW-1:0] MCMD_TDATA;
  logic          MCMD_TVALID;
  logic          MCMD_TREADY;
  logic [7:0]    MSTS_TDATA;
  logic          MSTS_TVALID;
  logic          MSTS_TREADY;
  logic          FETCH_BUSY;
  logic          FETCH_DONE;
  logic          FETCH_ERR;
  logic          FETCH_ERR_CLR;
  logic [15:0]   STAT_FRAMES;
  logic [15:0]   STAT_OVERRUN;

  dso100fb_fetch_ctrl dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .FETCH_EN        (FETCH_EN),
    .FETCH_START     (FETCH_START),
    .FETCH_FB_BASE   (FETCH_FB_BASE),
    .FETCH_FB_LENGTH (FETCH_FB_LENGTH),
    .MCMD_TDATA      (MCMD_TDATA),
    .MCMD_TVALID     (MCMD_TVALID),
    .MCMD_TREADY     (MCMD_TREADY),
    .MSTS_TDATA      (MSTS_TDATA),
    .MSTS_TVALID     (MSTS_TVALID),
    .MSTS_TREADY     (MSTS_TREADY),
    .FETCH_BUSY      (FETCH_BUSY),
    .FETCH_DONE      (FETCH_DONE),
    .FETCH_ERR       (FETCH_ERR),
    .FETCH_ERR_CLR   (FETCH_ERR_CLR),
    .STAT_FRAMES     (STAT_FRAMES),
    .STAT_OVERRUN    (STAT_OVERRUN)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] seen_q[$];
  logic [3:0]    sts_pend[$];
  logic [3:0]    model_tag;
  logic [3:0]    issue_tag;
  int            done_cnt;
  int            frames_exp;
  int            overrun_exp;
  bit            auto_sts;
  bit            rand_ready;
  bit            inj_valid;
  logic [7:0]    inj_data;
  bit            prev_stall;
  logic [CW-1:0] prev_data;
  logic [CW-1:0] hold;
  logic [AW-1:0] rbase;
  logic [LW-1:0] rlen;
  logic [3:0]    bad_hi[5]  = '{4'hC, 4'h8, 4'h0, 4'hA, 4'h9};
  logic [3:0]    bad_off[5] = '{4'd0, 4'd5, 4'd0, 4'd0, 4'd0};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: frame split into min(rem, CHUNK) pieces, tags continue across frames
  task automatic model_frame(input logic [AW-1:0] base, input logic [LW-1:0] len, input int max_cmds);
    logic [AW-1:0] a;
    int r;
    int b;
    int n;
    a = base;
    r = int'(len);
    n = 0;
    while (r > 0 && n < max_cmds) begin
      b = (r < CHUNK) ? r : CHUNK;
      exp_q.push_back({4'h0, model_tag, a, 1'b0, (b == r), 6'h00, 1'b1, BW'(b)});
      a = a + AW'(b);
      r = r - b;
      model_tag = model_tag + 4'd1;
      n++;
    end
  endtask

  // driver: one clock of stimulus, handshake capture and status responder
  task automatic step();
    MSTS_TVALID = 1'b0;
    MSTS_TDATA  = 8'h00;
    if (inj_valid) begin
      MSTS_TVALID = 1'b1;
      MSTS_TDATA  = inj_data;
      inj_valid   = 1'b0;
    end else if (auto_sts && sts_pend.size() > 0 && $urandom_range(0, 2) == 0) begin
      MSTS_TVALID = 1'b1;
      MSTS_TDATA  = {4'h8, sts_pend.pop_front()};
    end
    if (rand_ready) MCMD_TREADY = ($urandom_range(0, 2) != 0);
    if (MCMD_TVALID && MCMD_TREADY) begin
      seen_q.push_back(MCMD_TDATA);
      sts_pend.push_back(issue_tag);
      issue_tag = issue_tag + 4'd1;
    end
    prev_stall = MCMD_TVALID && !MCMD_TREADY;
    prev_data  = MCMD_TDATA;
    if (FETCH_DONE) done_cnt++;
    @(posedge CLK);
    #1;
    if (prev_stall) begin
      chk("hold_valid", MCMD_TVALID, 1'b1);
      chk("hold_data", MCMD_TDATA, prev_data);
    end
  endtask

  task automatic inject(input logic [7:0] data);
    inj_valid = 1'b1;
    inj_data  = data;
    if (sts_pend.size() > 0) void'(sts_pend.pop_front());
  endtask

  task automatic clear_err(input string tag);
    FETCH_ERR_CLR = 1'b1;
    step();
    FETCH_ERR_CLR = 1'b0;
    chk({tag, "_err_clr"}, FETCH_ERR, 1'b0);
  endtask

  task automatic do_reset();
    RST_N       = 1'b0;
    MSTS_TVALID = 1'b0;
    FETCH_START = 1'b0;
    #2;
    chk("rst_tvalid", MCMD_TVALID, 1'b0);
    chk("rst_tdata", MCMD_TDATA, '0);
    chk("rst_tready", MSTS_TREADY, 1'b1);
    chk("rst_busy", FETCH_BUSY, 1'b0);
    chk("rst_done", FETCH_DONE, 1'b0);
    chk("rst_err", FETCH_ERR, 1'b0);
    chk("rst_frames", STAT_FRAMES, 16'd0);
    chk("rst_overrun", STAT_OVERRUN, 16'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    exp_q.delete();
    seen_q.delete();
    sts_pend.delete();
    model_tag   = 4'd0;
    issue_tag   = 4'd0;
    prev_stall  = 1'b0;
    inj_valid   = 1'b0;
    frames_exp  = 0;
    overrun_exp = 0;
  endtask

  task automatic start_frame(input logic [AW-1:0] base, input logic [LW-1:0] len, input int max_cmds);
    model_frame(base, len, max_cmds);
    FETCH_FB_BASE   = base;
    FETCH_FB_LENGTH = len;
    FETCH_START     = 1'b1;
    step();
    FETCH_START     = 1'b0;
    FETCH_FB_BASE   = $urandom;
    FETCH_FB_LENGTH = LW'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_done"}, done_cnt - d0, 1);
    repeat (3) step();
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_idle"}, FETCH_BUSY, 1'b0);
    frames_exp++;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!MCMD_TVALID && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, MCMD_TVALID, 1'b1);
  endtask

  task automatic wait_pend(input string tag);
    int n;
    n = 0;
    while (sts_pend.size() == 0 && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_issued"}, sts_pend.size(), 1);
  endtask

  // scoreboard: observed handshakes against the model queue, in order
  task automatic compare_cmds(input string tag);
    int i;
    chk({tag, "_count"}, seen_q.size(), exp_q.size());
    i = 0;
    while (seen_q.size() > 0 && exp_q.size() > 0) begin
      chk($sformatf("%s_cmd%0d", tag, i), seen_q.pop_front(), exp_q.pop_front());
      i++;
    end
    seen_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_stats(input string tag);
`ifdef DSO100FB_FETCH_STATS_EN
    chk({tag, "_frames"}, STAT_FRAMES, 16'(frames_exp));
    chk({tag, "_overrun"}, STAT_OVERRUN, 16'(overrun_exp));
`else
    chk({tag, "_frames"}, STAT_FRAMES, 16'd0);
    chk({tag, "_overrun"}, STAT_OVERRUN, 16'd0);
`endif
  endtask

  initial begin
    RST_N           = 1'b0;
    FETCH_EN        = 1'b1;
    FETCH_START     = 1'b0;
    FETCH_FB_BASE   = '0;
    FETCH_FB_LENGTH = '0;
    MCMD_TREADY     = 1'b1;
    MSTS_TDATA      = 8'h00;
    MSTS_TVALID     = 1'b0;
    FETCH_ERR_CLR   = 1'b0;
    auto_sts        = 1'b0;
    rand_ready      = 1'b0;
    done_cnt        = 0;
    @(posedge CLK);
    #1;
    do_reset();

    // three chunks 4096/4096/1808, tags 0..2, EOF on the last
    auto_sts = 1'b1;
    start_frame(32'h1000_0000, LW'(10000), 99);
    wait_done("t1");
    compare_cmds("t1");
    chk("t1_err", FETCH_ERR, 1'b0);

    // outstanding limit: four commands then stall until one status returns
    auto_sts = 1'b0;
    start_frame(32'h2000_0000, LW'(32768), 99);
    repeat (40) step();
    chk("t2_cmds_capped", seen_q.size(), 4);
    chk("t2_valid_low", MCMD_TVALID, 1'b0);
    chk("t2_busy", FETCH_BUSY, 1'b1);
    inject({4'h8, sts_pend[0]});
    repeat (10) step();
    chk("t2_fifth", seen_q.size(), 5);
    auto_sts = 1'b1;
    wait_done("t2");
    compare_cmds("t2");
    chk("t2_err", FETCH_ERR, 1'b0);

    // TREADY stall holds the command stable, single transfer
    MCMD_TREADY = 1'b0;
    start_frame(32'h3000_0100, LW'(5000), 99);
    wait_valid("t3");
    hold = MCMD_TDATA;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_stall_valid", MCMD_TVALID, 1'b1);
      chk("t3_stall_data", MCMD_TDATA, hold);
    end
    MCMD_TREADY = 1'b1;
    wait_done("t3");
    compare_cmds("t3");
    chk("t3_err", FETCH_ERR, 1'b0);

    // async reset mid-frame, then stale/bad status handling
    start_frame(32'h4000_0000, LW'(20000), 99);
    repeat (6) step();
    chk("t4_busy_before_rst", FETCH_BUSY, 1'b1);
    do_reset();
    auto_sts = 1'b0;
    inject(8'h01);
    step();
    chk("t4_stale_err", FETCH_ERR, 1'b1);
    clear_err("t4_stale");
    inject(8'h80);
    FETCH_ERR_CLR = 1'b1;
    step();
    FETCH_ERR_CLR = 1'b0;
    chk("t4_set_wins", FETCH_ERR, 1'b1);
    clear_err("t4_set");
    for (int k = 0; k < 5; k++) begin
      start_frame(32'h4100_0000 + AW'(k * 'h40), LW'(CHUNK), 99);
      wait_pend($sformatf("t4b%0d", k));
      inject({bad_hi[k], sts_pend[0] + bad_off[k]});
      step();
      chk($sformatf("t4b%0d_err", k), FETCH_ERR, 1'b1);
      wait_done($sformatf("t4b%0d", k));
      compare_cmds($sformatf("t4b%0d", k));
      clear_err($sformatf("t4b%0d", k));
    end

    // start while busy is dropped; zero-length frame completes immediately
    auto_sts = 1'b1;
    start_frame(32'h5000_0000, LW'(20000), 99);
    repeat (4) step();
    chk("t5_busy", FETCH_BUSY, 1'b1);
    FETCH_FB_BASE   = 32'hDEAD_0000;
    FETCH_FB_LENGTH = LW'(100);
    FETCH_START     = 1'b1;
    step();
    FETCH_START     = 1'b0;
    overrun_exp++;
    wait_done("t5");
    compare_cmds("t5");
    chk_stats("t5");
    start_frame(32'h5555_0000, LW'(0), 99);
    chk("t5z_done_now", FETCH_DONE, 1'b1);
    chk("t5z_not_busy", FETCH_BUSY, 1'b0);
    wait_done("t5z");
    compare_cmds("t5z");
    chk_stats("t5z");

    // FETCH_EN dropped during a stall: pending command still goes, nothing after it
    MCMD_TREADY = 1'b0;
    start_frame(32'h6000_0000, LW'(20000), 1);
    wait_valid("t6");
    FETCH_EN = 1'b0;
    repeat (3) step();
    MCMD_TREADY = 1'b1;
    wait_done("t6");
    compare_cmds("t6");
    FETCH_EN = 1'b1;

    // randomized frames, random TREADY and status timing, some crossing the address wrap
    rand_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      rbase = $urandom;
      case ($urandom_range(0, 3))
        0:       rlen = LW'(CHUNK * $urandom_range(0, 5));
        1:       rlen = LW'($urandom_range(1, CHUNK));
        default: rlen = LW'($urandom_range(1, 30000));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        rbase = 32'hFFFF_F000 + AW'($urandom_range(0, 4095));
        rlen  = LW'($urandom_range(8192, 20000));
      end
      start_frame(rbase, rlen, 99);
      wait_done($sformatf("rnd%0d", f));
      compare_cmds($sformatf("rnd%0d", f));
      chk($sformatf("rnd%0d_err", f), FETCH_ERR, 1'b0);
    end
    rand_ready  = 1'b0;
    MCMD_TREADY = 1'b1;
    chk_stats("final");

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
